uart_msg_scheduler: RTL
=======================

// Module: uart_msg_scheduler
// PURPOSE
//  Shares one txuart transmitter between N_REQ alert sources (intruder, fire, door, ...).
//  Each source pulses a request; the block queues it and round-robin arbitrates.
//  It streams the granted source's fixed-length ROM message byte-by-byte on the
//  txuart stb/busy handshake, then pulses a per-source done.
//  Sits between the alert logic and txuart, replacing per-message free-running send logic.
// PARAMETERS
//  N_REQ    4    number of requesters / messages in ROM
//  MSG_LEN  16   bytes per message (all messages padded to this length)
//  REQ_W    $clog2(N_REQ)    grant index width (derived)
//  IDX_W    $clog2(MSG_LEN)  byte index width (derived)
// PORTS
//  i_clk      in   1      system clock (50 MHz)
//  i_rst_n    in   1      one clock; reset is asynchronous and active-low
//  i_req      in   N_REQ  request pulses/levels, one bit per source
//  i_tx_busy  in   1      txuart busy; byte accepted on o_tx_stb && !i_tx_busy
//  o_tx_stb   out  1      byte valid strobe to txuart
//  o_tx_data  out  8      byte to txuart; stable while o_tx_stb high
//  o_active   out  1      message in flight (state != IDLE)
//  o_grant    out  REQ_W  index of source being sent; valid while o_active
//  o_pending  out  N_REQ  queued requests not yet granted
//  o_done     out  N_REQ  1-cycle pulse on bit g when message g fully accepted
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, o_tx_stb=0, o_tx_data=0, o_pending=0,
//   o_done=0, o_grant=0, rr pointer=0, byte idx=0. Release mid-message: no residue.
//  Pending: i_req[k]=1 at edge sets pend[k]; one entry per source (no counting).
//   Set and grant-clear of same bit on same edge: set wins (stays pending).
//   Request from source currently sending queues one repeat.
//  FSM: IDLE -> LOAD -> SEND -> (LOAD | DONE) -> IDLE.
//   IDLE: if |pend: grant = first set bit searching from rr upward (mod N_REQ);
//     clear pend[grant]; idx=0; -> LOAD. Else stay.
//   LOAD: o_tx_data <= rom[grant][idx]; o_tx_stb <= 1; -> SEND.
//   SEND: hold stb/data until o_tx_stb && !i_tx_busy (accept). On accept:
//     o_tx_stb <= 0; if idx==MSG_LEN-1 -> DONE else idx++ -> LOAD.
//   DONE: o_done[grant]=1 for this cycle only; rr <= (grant+1) mod N_REQ; -> IDLE.
//  Latency: req edge t -> pend t+1 -> grant t+2 -> o_tx_stb high t+3.
//   Per byte: 2 cycles overhead (LOAD, accept) plus txuart busy time.
//  i_tx_busy high when stb rises: wait; no timeout. i_tx_busy ignored outside SEND.
//  idx wraps never: MSG_LEN-1 terminates. rr wraps N_REQ-1 -> 0.
//  Non-granted requests arriving during a message only accumulate in pend.
// STRUCTURE
//  Package uart_msg_pkg: state enum (IDLE, LOAD, SEND, DONE), N_REQ/MSG_LEN defaults,
//   message byte constants.
//  Sub-module uart_msg_rom (grant, idx -> byte, combinational/registered-once),
//   holding N_REQ x MSG_LEN ASCII table; msg 0 = "INTRUDER ALERT\r\n".
//  Top holds pend regs, rr arbiter, FSM, byte index, strobe/data regs.
// TESTING  (N_REQ=4, MSG_LEN=16; txuart model: busy 10 cycles after each accept)
//  1 Single req[0] pulse -> 16 bytes "INTRUDER ALERT\r\n" in order, o_done[0] one pulse,
//    o_tx_stb high at t+3, o_active low after DONE.
//  2 req=4'b1111 same cycle, rr=0 -> messages sent in order 0,1,2,3; o_done bits
//    pulse in that order; o_pending drains 1111->1110->1100->1000->0000.
//  3 After msg 2 completes, req[0] and req[3] together -> grant 3 first (rr=3), then 0.
//  4 Hold i_tx_busy=1 for 100 cycles at a byte -> o_tx_stb and o_tx_data stable
//    throughout; accept on first cycle busy=0; no byte dropped or duplicated.
//  5 req[1] re-pulsed 3 times during its own message -> exactly one repeat message.
//  6 Assert i_rst_n=0 at byte 7 -> o_tx_stb, o_pending, o_active 0 immediately (async);
//    after release, no output until a new request.

Source files
------------

// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART alert-message scheduler.
// The ROM layout covers the default N_REQ x MSG_LEN message set.
package uart_msg_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned MSG_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [MSG_LEN_DEF*8-1:0] MSG_INTRUDER = "INTRUDER ALERT\r\n";
  localparam logic [MSG_LEN_DEF*8-1:0] MSG_FIRE     = "FIRE ALARM!!!!\r\n";
  localparam logic [MSG_LEN_DEF*8-1:0] MSG_DOOR     = "DOOR OPENED!!!\r\n";
  localparam logic [MSG_LEN_DEF*8-1:0] MSG_PANIC    = "PANIC BUTTON!!\r\n";

  // Byte k of this array is the last-minus-k character of the packed strings, message 0 lowest.
  localparam logic [N_REQ_DEF*MSG_LEN_DEF-1:0][7:0] MSG_ROM =
    {MSG_PANIC, MSG_DOOR, MSG_FIRE, MSG_INTRUDER};

endpackage

// File: rtl/uart_msg_rom.sv
// Combinational message ROM: selects byte idx of message grant.
module uart_msg_rom
  import uart_msg_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned MSG_LEN = MSG_LEN_DEF,
  localparam int unsigned REQ_W  = $clog2(N_REQ),
  localparam int unsigned IDX_W  = $clog2(MSG_LEN)
) (
  input  logic [REQ_W-1:0] grant,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data_c
);

  // Strings pack their first character highest, so the in-message offset is inverted.
  assign data_c = MSG_ROM[{grant, ~idx}];

endmodule

// File: rtl/uart_msg_scheduler.sv
// Round-robin scheduler sharing one txuart between N_REQ alert sources,
// streaming each granted source's ROM message over the stb/busy handshake.
module uart_msg_scheduler
  import uart_msg_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned MSG_LEN = MSG_LEN_DEF,
  localparam int unsigned REQ_W  = $clog2(N_REQ),
  localparam int unsigned IDX_W  = $clog2(MSG_LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_tx_busy,
  output logic             o_tx_stb,
  output logic [7:0]       o_tx_data,
  output logic             o_active,
  output logic [REQ_W-1:0] o_grant,
  output logic [N_REQ-1:0] o_pending,
  output logic [N_REQ-1:0] o_done
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_e           state;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant_clr_c;
  logic [REQ_W-1:0] rr;
  logic [REQ_W-1:0] grant;
  logic [REQ_W-1:0] pick_c;
  logic [IDX_W-1:0] idx;
  logic             tx_stb;
  logic             active;
  logic [7:0]       tx_data;
  logic [7:0]       rom_data_c;

  uart_msg_rom #(
    .N_REQ   (N_REQ),
    .MSG_LEN (MSG_LEN)
  ) u_rom (
    .grant  (grant),
    .idx    (idx),
    .data_c (rom_data_c)
  );

  // First pending source at or above rr, wrapping; walked downward so the nearest wins.
  always_comb begin
    pick_c = rr;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (pend[rr + REQ_W'(i)]) pick_c = rr + REQ_W'(i);
    end
    grant_clr_c = (state == IDLE && |pend) ? (ONE_HOT0 << pick_c) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      pend    <= '0;
      done    <= '0;
      rr      <= '0;
      grant   <= '0;
      idx     <= '0;
      tx_stb  <= 1'b0;
      tx_data <= 8'h00;
      active  <= 1'b0;
    end else begin
      // A new request on the grant edge survives the clear, queueing one repeat.
      pend <= (pend & ~grant_clr_c) | i_req;
      done <= '0;
      case (state)
        IDLE: begin
          if (|pend) begin
            grant  <= pick_c;
            idx    <= '0;
            active <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          tx_data <= rom_data_c;
          tx_stb  <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (tx_stb && !i_tx_busy) begin
            tx_stb <= 1'b0;
            if (idx == IDX_W'(MSG_LEN - 1)) begin
              done  <= ONE_HOT0 << grant;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end
        end
        DONE: begin
          rr     <= grant + 1'b1;
          active <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_tx_stb  = tx_stb;
  assign o_tx_data = tx_data;
  assign o_active  = active;
  assign o_grant   = grant;
  assign o_pending = pend;
  assign o_done    = done;

endmodule
